// File: rtl/sisc_pkg.sv
// Shared SISC definitions: default bus widths, counter width, memory-arbiter state
// and owner encodings.
package sisc_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    // Wide enough for MEM_LAT-1 and MAX_DATA_RUN (both at most 15).
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_prio.sv
// Grant selection for mem_arb (purely combinational).
//   if_req_i, dm_req_i : pending requests
//   run_cnt_i          : consecutive contended data grants so far
//   owner_o            : winning requester
//   grant_valid_o      : at least one request is pending
//   contended_o        : both requests are pending
module arb_prio #(
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic                        if_req_i,
    input  logic                        dm_req_i,
    input  logic [sisc_pkg::CNT_W-1:0]  run_cnt_i,
    output sisc_pkg::owner_t            owner_o,
    output logic                        grant_valid_o,
    output logic                        contended_o
);
    import sisc_pkg::*;

    always_comb begin
        owner_o       = OWN_IF;
        grant_valid_o = if_req_i | dm_req_i;
        contended_o   = if_req_i & dm_req_i;
        if (contended_o) begin
            // Data wins until it has used up its run, then fetch gets one slot.
            owner_o = (run_cnt_i == CNT_W'(MAX_DATA_RUN)) ? OWN_IF : OWN_DM;
        end else if (dm_req_i) begin
            owner_o = OWN_DM;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter sharing one memory between instruction fetch and
// data access. Each access holds mem_en for MEM_LAT cycles, then pulses the
// owner's rdy for one cycle, then spends one mandatory idle cycle.
//   clk, rst_f                              : clock, async active-low reset
//   if_req/if_addr -> if_rdy/if_rdata       : fetch port
//   dm_req/dm_we/dm_addr/dm_wdata
//                  -> dm_rdy/dm_rdata       : data port
//   mem_en/mem_we/mem_addr/mem_wdata,
//   mem_rdata                               : memory side
//   busy                                    : arbiter not idle
module mem_arb #(
    parameter int unsigned ADDR_W       = sisc_pkg::ADDR_W,
    parameter int unsigned DATA_W       = sisc_pkg::DATA_W,
    parameter int unsigned MEM_LAT      = 2,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rdy,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_rdy,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    import sisc_pkg::*;

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    owner_t            grant_owner;
    logic              grant_valid;
    logic              contended;

    arb_prio #(
        .MAX_DATA_RUN (MAX_DATA_RUN)
    ) u_arb_prio (
        .if_req_i      (if_req),
        .dm_req_i      (dm_req),
        .run_cnt_i     (run_cnt_q),
        .owner_o       (grant_owner),
        .grant_valid_o (grant_valid),
        .contended_o   (contended)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        run_cnt_d  = run_cnt_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_owner;
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                    state_d = ARB_ACCESS;
                    if (grant_owner == OWN_DM) begin
                        addr_d    = dm_addr;
                        we_d      = dm_we;
                        wdata_d   = dm_wdata;
                        run_cnt_d = contended ? run_cnt_q + 1'b1 : '0;
                    end else begin
                        addr_d    = if_addr;
                        we_d      = 1'b0;
                        run_cnt_d = '0;
                    end
                end
            end
            ARB_ACCESS: begin
                if (cnt_q == '0) begin
                    // we_q is never set for fetch, so this covers every read.
                    if (!we_q) begin
                        if (owner_q == OWN_IF) begin
                            if_rdata_d = mem_rdata;
                        end else begin
                            dm_rdata_d = mem_rdata;
                        end
                    end
                    state_d = ARB_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= ARB_IDLE;
            cnt_q      <= '0;
            run_cnt_q  <= '0;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            run_cnt_q  <= run_cnt_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Outputs decode only state and latched registers, never requester inputs.
    always_comb begin
        mem_en    = (state_q == ARB_ACCESS);
        mem_we    = mem_en & (owner_q == OWN_DM) & we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_rdy    = (state_q == ARB_RESP) & (owner_q == OWN_IF);
        dm_rdy    = (state_q == ARB_RESP) & (owner_q == OWN_DM);
        busy      = (state_q != ARB_IDLE);
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
    end

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;

    localparam int unsigned LAT    = 2;
    localparam int unsigned MAXRUN = 4;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        mem_load = 1'b1;

    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_rdy;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [15:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_rdy;
    logic [31:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy;

    // Second instance with MEM_LAT = 1, fetch port only.
    logic        if_req1 = 1'b0;
    logic [15:0] if_addr1 = '0;
    logic        if_rdy1;
    logic [31:0] if_rdata1;
    logic        dm_req1 = 1'b0;
    logic        dm_we1 = 1'b0;
    logic [15:0] dm_addr1 = '0;
    logic [31:0] dm_wdata1 = '0;
    logic        dm_rdy1;
    logic [31:0] dm_rdata1;
    logic        mem_en1, mem_we1;
    logic [15:0] mem_addr1;
    logic [31:0] mem_wdata1, mem_rdata1;
    logic        busy1;

    logic [31:0] phys_mem [256];
    logic [31:0] ref_mem  [256];

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(LAT), .MAX_DATA_RUN(MAXRUN)) dut (
        .clk(clk), .rst_f(rst_f),
        .if_req(if_req), .if_addr(if_addr), .if_rdy(if_rdy), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdy(dm_rdy), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1), .MAX_DATA_RUN(MAXRUN)) dut1 (
        .clk(clk), .rst_f(rst_f),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdy(if_rdy1), .if_rdata(if_rdata1),
        .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
        .dm_rdy(dm_rdy1), .dm_rdata(dm_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'hA5A5_0001 : {16'hC0DE, 8'h00, 8'(i)};
    endfunction

    // Memory array driven by the DUTs; only dut ever writes.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) phys_mem[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            phys_mem[mem_addr[7:0]] <= mem_wdata;
        end
    end
    assign mem_rdata  = phys_mem[mem_addr[7:0]];
    assign mem_rdata1 = phys_mem[mem_addr1[7:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One uncontended transaction on dut, called at +1 of an idle cycle.
    task automatic access(input bit is_dm, input bit we, input logic [15:0] addr,
                          input logic [31:0] wd, input bit drop_mid);
        logic [31:0] if_before, dm_before;
        bit          wr;
        wr        = is_dm && we;
        if_before = if_rdata;
        dm_before = dm_rdata;
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        tick();
        for (int c = 1; c <= int'(LAT); c++) begin
            check("acc_mem_en", mem_en, 1);
            check("acc_mem_we", mem_we, wr);
            check("acc_mem_addr", mem_addr, addr);
            if (wr) check("acc_mem_wdata", mem_wdata, wd);
            check("acc_no_rdy", {if_rdy, dm_rdy}, 0);
            check("acc_busy", busy, 1);
            // Inputs moving while owned must be ignored.
            if_addr = 16'($urandom); dm_addr = 16'($urandom);
            dm_wdata = $urandom; dm_we = 1'($urandom);
            if (drop_mid) begin if_req = 1'b0; dm_req = 1'b0; end
            tick();
        end
        check("resp_mem_en", mem_en, 0);
        check("resp_rdy", {if_rdy, dm_rdy}, is_dm ? 2'b01 : 2'b10);
        check("resp_busy", busy, 1);
        if (!is_dm) begin
            check("if_rdata", if_rdata, ref_mem[addr[7:0]]);
            check("dm_rdata_kept", dm_rdata, dm_before);
        end else if (!we) begin
            check("dm_rdata", dm_rdata, ref_mem[addr[7:0]]);
            check("if_rdata_kept", if_rdata, if_before);
        end else begin
            check("dm_rdata_wr_kept", dm_rdata, dm_before);
            ref_mem[addr[7:0]] = wd;
        end
        if_req = 1'b0; dm_req = 1'b0;
        tick();
        check("idle_busy", busy, 0);
        check("idle_rdy", {if_rdy, dm_rdy}, 0);
    endtask

    initial begin
        int          grants;
        int          last;
        bit          exp_if;
        logic [15:0] a [5];

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // Reset state
        #12;
        check("rst_if_rdy", if_rdy, 0);
        check("rst_dm_rdy", dm_rdy, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        @(negedge clk);
        rst_f = 1'b1;
        mem_load = 1'b0;
        tick();

        // Directed: fetch, write, read-back, dropped data request
        access(1'b0, 1'b0, 16'h0010, 32'h0, 1'b0);
        check("fetch_0010", if_rdata, 32'hA5A5_0001);
        access(1'b1, 1'b1, 16'h0040, 32'hDEAD_BEEF, 1'b0);
        access(1'b1, 1'b0, 16'h0040, 32'h0, 1'b0);
        check("readback_0040", dm_rdata, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 16'h0010, 32'h0, 1'b1);

        // Randomized uncontended traffic against the reference memory
        for (int n = 0; n < 30; n++) begin
            access(1'($urandom), 1'($urandom), 16'($urandom), $urandom,
                   ($urandom_range(0, 3) == 0));
        end

        // Both requests held: data gets MAXRUN slots, then fetch gets one
        if_req = 1'b1; if_addr = 16'h0010;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0040;
        grants = 0;
        last   = 0;
        for (int c = 1; c <= 42; c++) begin
            tick();
            check("rdy_overlap", if_rdy & dm_rdy, 0);
            if (if_rdy | dm_rdy) begin
                exp_if = (grants % (MAXRUN + 1)) == MAXRUN;
                check("grant_owner", {if_rdy, dm_rdy}, exp_if ? 2'b10 : 2'b01);
                check("grant_gap", c - last, (grants == 0) ? LAT + 1 : LAT + 2);
                if (if_rdy) check("cont_if_rdata", if_rdata, ref_mem[8'h10]);
                else        check("cont_dm_rdata", dm_rdata, ref_mem[8'h40]);
                last = c;
                grants++;
            end
        end
        check("grant_count", grants, 10);
        if_req = 1'b0; dm_req = 1'b0;
        for (int i = 0; i < 8 && busy; i++) tick();
        check("drain_busy", busy, 0);
        tick();

        // MEM_LAT = 1 back-to-back fetches, address changed mid-access
        for (int k = 0; k < 5; k++) a[k] = 16'($urandom);
        if_req1 = 1'b1; if_addr1 = a[0];
        for (int k = 0; k < 4; k++) begin
            tick();
            check("b2b_mem_en", mem_en1, 1);
            check("b2b_mem_addr", mem_addr1, a[k]);
            check("b2b_mem_we", mem_we1, 0);
            check("b2b_no_rdy", if_rdy1, 0);
            if_addr1 = a[k+1];
            tick();
            check("b2b_rdy", if_rdy1, 1);
            check("b2b_mem_en_off", mem_en1, 0);
            check("b2b_rdata", if_rdata1, ref_mem[a[k][7:0]]);
            check("b2b_dm_rdy", dm_rdy1, 0);
            tick();
            check("b2b_idle_rdy", if_rdy1, 0);
            check("b2b_idle_busy", busy1, 0);
        end
        if_req1 = 1'b0;
        check("b2b_dm_rdata", dm_rdata1, 0);
        check("b2b_mem_wdata", mem_wdata1, 0);
        tick();

        // Reset asserted mid-access (harmless write: same value as stored)
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0033; dm_wdata = ref_mem[8'h33];
        tick();
        check("mid_pre_en", mem_en, 1);
        check("mid_pre_we", mem_we, 1);
        #2 rst_f = 1'b0;
        #1;
        check("mid_rst_en", mem_en, 0);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", mem_addr, 0);
        dm_req = 1'b0;
        @(negedge clk);
        rst_f = 1'b1;
        for (int i = 0; i < int'(LAT) + 3; i++) begin
            tick();
            check("mid_no_rdy", {if_rdy, dm_rdy}, 0);
            check("mid_idle", busy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
